// File: rtl/tick_timer_pkg.sv
// Shared types for the tick timer: FSM state encoding and a busy decode helper.
package tick_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10
  } state_t;

  function automatic logic is_busy(input state_t s);
    return (s == RUN) || (s == HOLD);
  endfunction

endpackage

// File: rtl/tick_timer_rgst.sv
// Loadable register with synchronous clear; holds the timer period.
module rgst #(
  parameter int w = 8
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         ld,
  input  logic         clr,
  input  logic [w-1:0] d,
  output logic [w-1:0] q
);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)   q <= '0;
    else if (clr) q <= '0;
    else if (ld)  q <= d;
  end

endmodule

// File: rtl/tick_timer.sv
// Tick-driven down-counting timer, one-shot or periodic, with pause/resume and start rejection.
//
//   state | meaning
//   IDLE  | no period in progress; start loads cnt from the period register
//   RUN   | counting down one per tick; expiry pulses done
//   HOLD  | paused, cnt frozen; start resumes without reload
module tick_timer
  import tick_timer_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         tick,
  input  logic         clr,
  input  logic         ld_per,
  input  logic [W-1:0] per_in,
  input  logic         start,
  input  logic         stop,
  input  logic         mode,
  output logic [W-1:0] cnt,
  output logic         busy,
  output logic         done,
  output logic         err
);

  state_t       state;
  logic         mode_q;
  logic [W-1:0] per;

  // The FSM reads per before this edge's load lands, so a reload coinciding
  // with ld_per uses the old period.
  rgst #(.w(W)) u_per (
    .clk   (clk),
    .rst_b (rst_b),
    .ld    (ld_per),
    .clr   (1'b0),
    .d     (per_in),
    .q     (per)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state  <= IDLE;
      cnt    <= '0;
      mode_q <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (clr) begin
        state <= IDLE;
        cnt   <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (per != '0) begin
                state  <= RUN;
                cnt    <= per;
                mode_q <= mode;
                busy   <= 1'b1;
              end else begin
                err <= 1'b1;
              end
            end
          end
          RUN: begin
            if (stop) begin
              state <= HOLD;
            end else if (tick) begin
              // <= 1 rather than == 1 so cnt can never wrap below zero
              if (cnt <= W'(1)) begin
                done <= 1'b1;
                if (mode_q && per != '0) begin
                  cnt <= per;
                end else begin
                  cnt   <= '0;
                  state <= IDLE;
                  busy  <= 1'b0;
                end
              end else begin
                cnt <= cnt - W'(1);
              end
            end
          end
          HOLD: begin
            if (start) state <= RUN;
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tick_timer.sv
// Directed bench for tick_timer: one-shot, periodic, pause, reject, clear, reset.
module tb_tick_timer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_b = 1'b0;
  logic         tick = 1'b0;
  logic         clr = 1'b0;
  logic         ld_per = 1'b0;
  logic [W-1:0] per_in = '0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] cnt;
  logic         busy;
  logic         done;
  logic         err;

  int n_run = 0;
  int n_fail = 0;
  int n_done;

  tick_timer #(.W(W)) dut (
    .clk    (clk),
    .rst_b  (rst_b),
    .tick   (tick),
    .clr    (clr),
    .ld_per (ld_per),
    .per_in (per_in),
    .start  (start),
    .stop   (stop),
    .mode   (mode),
    .cnt    (cnt),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // one clock with the given strobes, outputs then sampled 1 time unit after the edge
  task automatic cyc(input logic t, input logic s, input logic p, input logic c);
    tick = t; start = s; stop = p; clr = c;
    @(posedge clk); #1;
    tick = 1'b0; start = 1'b0; stop = 1'b0; clr = 1'b0;
  endtask

  task automatic load(input logic [W-1:0] v);
    ld_per = 1'b1; per_in = v;
    @(posedge clk); #1;
    ld_per = 1'b0;
  endtask

  initial begin
    byte exp_c[6] = '{1, 2, 1, 2, 1, 2};

    #12;
    chk("rst_cnt", cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst_b = 1'b1;
    @(posedge clk); #1;

    // one-shot, period 3
    load(3); mode = 1'b0;
    cyc(0, 1, 0, 0);
    chk("os_cnt3", cnt, 3);
    chk("os_busy", busy, 1);
    cyc(1, 0, 0, 0); chk("os_cnt2", cnt, 2);
    cyc(1, 0, 0, 0); chk("os_cnt1", cnt, 1); chk("os_nodone", done, 0);
    cyc(1, 0, 0, 0);
    chk("os_cnt0", cnt, 0); chk("os_done", done, 1); chk("os_idle", busy, 0);
    cyc(1, 0, 0, 0);
    chk("os_done_1cyc", done, 0); chk("os_tick_idle", cnt, 0);

    // periodic, period 2
    load(2); mode = 1'b1;
    cyc(0, 1, 0, 0);
    chk("pr_cnt0", cnt, 2);
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1, 0, 0, 0);
      chk($sformatf("pr_cnt%0d", i + 1), cnt, exp_c[i]);
      chk($sformatf("pr_done%0d", i + 1), done, (i % 2 == 1));
      if (done) n_done++;
    end
    chk("pr_ndone", n_done, 3);
    chk("pr_busy", busy, 1);

    // reload coincident with a period load uses the old period
    cyc(1, 0, 0, 0); chk("ld_cnt1", cnt, 1);
    ld_per = 1'b1; per_in = 7;
    cyc(1, 0, 0, 0);
    ld_per = 1'b0;
    chk("ld_reload_old", cnt, 2); chk("ld_done", done, 1);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("ld_reload_new", cnt, 7);
    cyc(0, 0, 0, 1);
    chk("ld_clr_cnt", cnt, 0); chk("ld_clr_busy", busy, 0);

    // pause / resume, period 5 one-shot
    load(5); mode = 1'b0;
    cyc(0, 1, 0, 0); chk("ps_cnt5", cnt, 5);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0); chk("ps_cnt3", cnt, 3);
    cyc(0, 0, 1, 0); chk("ps_hold_busy", busy, 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
    chk("ps_hold_cnt", cnt, 3);
    cyc(0, 1, 0, 0); chk("ps_resume_cnt", cnt, 3); chk("ps_resume_busy", busy, 1);
    n_done = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0);
      if (done) n_done++;
    end
    chk("ps_cnt_end", cnt, 0); chk("ps_ndone", n_done, 1); chk("ps_idle", busy, 0);

    // reject on zero period, then start+stop priority from RUN
    load(0);
    cyc(0, 1, 0, 0);
    chk("rj_err", err, 1); chk("rj_busy", busy, 0);
    cyc(0, 0, 0, 0); chk("rj_err_1cyc", err, 0);
    load(4);
    cyc(0, 1, 0, 0); chk("pri_cnt4", cnt, 4);
    cyc(0, 1, 1, 0);
    cyc(1, 0, 0, 0);
    chk("pri_hold_cnt", cnt, 4); chk("pri_hold_busy", busy, 1);
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0); chk("pri_resume", cnt, 3);
    cyc(0, 0, 0, 1);

    // clear coincident with the final tick
    load(3);
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0); chk("cl_cnt1", cnt, 1);
    cyc(1, 0, 0, 1);
    chk("cl_cnt", cnt, 0); chk("cl_busy", busy, 0); chk("cl_done", done, 0);
    cyc(0, 0, 0, 0); chk("cl_done_late", done, 0);

    // asynchronous reset mid-RUN, period register cleared too
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0); chk("ar_cnt2", cnt, 2);
    #3 rst_b = 1'b0;
    #1;
    chk("ar_cnt", cnt, 0); chk("ar_busy", busy, 0); chk("ar_done", done, 0);
    #2 rst_b = 1'b1;
    @(posedge clk); #1;
    chk("ar_nodone", done, 0);
    cyc(0, 1, 0, 0);
    chk("ar_err", err, 1); chk("ar_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
